// File: rtl/tri_raster_walk.sv
// Triangle traversal: walks the clipped bounding box in raster order, one position
// per cycle, updating three edge functions with adders and streaming covered pixels.
module tri_raster_walk #(
  parameter int SCREEN_W      = 320,
  parameter int SCREEN_H      = 240,
  parameter int BOTH_WINDINGS = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               raster_start,
  input  logic signed [9:0]  a1,
  input  logic signed [9:0]  b1,
  input  logic signed [9:0]  a2,
  input  logic signed [9:0]  b2,
  input  logic signed [9:0]  a3,
  input  logic signed [9:0]  b3,
  input  logic signed [17:0] c1,
  input  logic signed [17:0] c2,
  input  logic signed [17:0] c3,
  input  logic [8:0]         bbxi,
  input  logic [8:0]         bbxf,
  input  logic [7:0]         bbyi,
  input  logic [7:0]         bbyf,
  output logic               raster_busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [8:0]         pix_x,
  output logic [7:0]         pix_y,
  output logic               raster_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    WALK  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [8:0] X_LAST = 9'(SCREEN_W - 1);
  localparam logic [7:0] Y_LAST = 8'(SCREEN_H - 1);

  state_t             state_r, state_s;
  logic signed [9:0]  a_r [3];
  logic signed [9:0]  a_s [3];
  logic signed [9:0]  b_r [3];
  logic signed [9:0]  b_s [3];
  logic signed [17:0] c_r [3];
  logic signed [17:0] c_s [3];
  logic signed [20:0] e_r [3];
  logic signed [20:0] e_s [3];
  logic signed [20:0] erow_r [3];
  logic signed [20:0] erow_s [3];
  logic [8:0]         bbxi_r, bbxi_s, xf_r, xf_s, x_r, x_s;
  logic [7:0]         bbyi_r, bbyi_s, yf_r, yf_s, y_r, y_s;
  logic               pix_valid_r, pix_valid_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               advance_s;

  function automatic logic signed [20:0] mul_coef(input logic signed [9:0] k,
                                                  input logic [8:0] p);
    logic signed [20:0] ks;
    logic signed [20:0] ps;
    ks = {{11{k[9]}}, k};
    ps = $signed({12'd0, p});
    return ks * ps;
  endfunction

  function automatic logic signed [20:0] ext_const(input logic signed [17:0] k);
    return {{3{k[17]}}, k};
  endfunction

  function automatic logic signed [20:0] ext_coef(input logic signed [9:0] k);
    return {{11{k[9]}}, k};
  endfunction

  function automatic logic is_inside(input logic signed [20:0] e0,
                                     input logic signed [20:0] e1,
                                     input logic signed [20:0] e2);
    logic all_pos;
    logic all_neg;
    all_pos = !e0[20] && !e1[20] && !e2[20];
    all_neg = (e0 <= 21'sd0) && (e1 <= 21'sd0) && (e2 <= 21'sd0);
    return all_pos || ((BOTH_WINDINGS != 0) && all_neg);
  endfunction

  // Next-state, datapath update and next registered outputs.
  always_comb begin
    state_s   = state_r;
    bbxi_s    = bbxi_r;
    xf_s      = xf_r;
    bbyi_s    = bbyi_r;
    yf_s      = yf_r;
    x_s       = x_r;
    y_s       = y_r;
    for (int i = 0; i < 3; i++) begin
      a_s[i]    = a_r[i];
      b_s[i]    = b_r[i];
      c_s[i]    = c_r[i];
      e_s[i]    = e_r[i];
      erow_s[i] = erow_r[i];
    end
    // A held pixel only moves once downstream takes it.
    advance_s = !pix_valid_r || pix_ready;

    case (state_r)
      IDLE: begin
        if (raster_start) begin
          a_s[0] = a1;  a_s[1] = a2;  a_s[2] = a3;
          b_s[0] = b1;  b_s[1] = b2;  b_s[2] = b3;
          c_s[0] = c1;  c_s[1] = c2;  c_s[2] = c3;
          bbxi_s  = bbxi;
          bbyi_s  = bbyi;
          xf_s    = (bbxf > X_LAST) ? X_LAST : bbxf;
          yf_s    = (bbyf > Y_LAST) ? Y_LAST : bbyf;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if ((bbxi_r > xf_r) || (bbyi_r > yf_r)) begin
          state_s = DONE;
        end else begin
          for (int i = 0; i < 3; i++) begin
            e_s[i]    = mul_coef(a_r[i], bbxi_r) + mul_coef(b_r[i], {1'b0, bbyi_r})
                        + ext_const(c_r[i]);
            erow_s[i] = e_s[i];
          end
          x_s     = bbxi_r;
          y_s     = bbyi_r;
          state_s = WALK;
        end
      end
      WALK: begin
        if (!advance_s) begin
          state_s = WALK;
        end else if (x_r < xf_r) begin
          x_s = x_r + 9'd1;
          for (int i = 0; i < 3; i++) begin
            e_s[i] = e_r[i] + ext_coef(a_r[i]);
          end
        end else if (y_r < yf_r) begin
          x_s = bbxi_r;
          y_s = y_r + 8'd1;
          for (int i = 0; i < 3; i++) begin
            erow_s[i] = erow_r[i] + ext_coef(b_r[i]);
            e_s[i]    = erow_s[i];
          end
        end else begin
          state_s = DONE;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    pix_valid_s = (state_s == WALK) && is_inside(e_s[0], e_s[1], e_s[2]);
    busy_s      = (state_s != IDLE);
    done_s      = (state_s == DONE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bbxi_r      <= 9'd0;
      xf_r        <= 9'd0;
      bbyi_r      <= 8'd0;
      yf_r        <= 8'd0;
      x_r         <= 9'd0;
      y_r         <= 8'd0;
      pix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        a_r[i]    <= 10'sd0;
        b_r[i]    <= 10'sd0;
        c_r[i]    <= 18'sd0;
        e_r[i]    <= 21'sd0;
        erow_r[i] <= 21'sd0;
      end
    end else begin
      state_r     <= state_s;
      bbxi_r      <= bbxi_s;
      xf_r        <= xf_s;
      bbyi_r      <= bbyi_s;
      yf_r        <= yf_s;
      x_r         <= x_s;
      y_r         <= y_s;
      pix_valid_r <= pix_valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      for (int i = 0; i < 3; i++) begin
        a_r[i]    <= a_s[i];
        b_r[i]    <= b_s[i];
        c_r[i]    <= c_s[i];
        e_r[i]    <= e_s[i];
        erow_r[i] <= erow_s[i];
      end
    end
  end

  assign raster_busy = busy_r;
  assign pix_valid   = pix_valid_r;
  assign pix_x       = x_r;
  assign pix_y       = y_r;
  assign raster_done = done_r;

endmodule

// File: tb/tb_tri_raster_walk.sv
// Scoreboard bench for tri_raster_walk: stimulus pushes expected pixels and done
// latencies; a negedge monitor pops and compares them as the DUT presents them.
module tb_tri_raster_walk;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               raster_start = 1'b0;
  logic signed [9:0]  a1, b1, a2, b2, a3, b3;
  logic signed [17:0] c1, c2, c3;
  logic [8:0]         bbxi, bbxf;
  logic [7:0]         bbyi, bbyf;
  logic               pix_ready = 1'b1;
  logic               raster_busy, pix_valid, raster_done;
  logic [8:0]         pix_x;
  logic [7:0]         pix_y;
  logic               busy0, valid0, done0;
  logic [8:0]         x0;
  logic [7:0]         y0;

  typedef struct packed {
    logic [8:0]  x;
    logic [7:0]  y;
    logic [15:0] rel;
  } pix_t;

  pix_t exp_q[$];
  int   done_q[$];
  int   cyc = 0;
  int   start_cyc = 0;
  int   done_cnt = 0;
  int   total = 0;
  int   passed = 0;
  bit   neg_test = 1'b0;
  int   neg_pix = 0;
  int   done0_rel = -1;

  tri_raster_walk #(.SCREEN_W(320), .SCREEN_H(240), .BOTH_WINDINGS(1)) dut (
    .clk(clk), .rst_n(rst_n), .raster_start(raster_start),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .raster_busy(raster_busy), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .raster_done(raster_done)
  );

  tri_raster_walk #(.SCREEN_W(320), .SCREEN_H(240), .BOTH_WINDINGS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .raster_start(raster_start),
    .a1(a1), .b1(b1), .a2(a2), .b2(b2), .a3(a3), .b3(b3),
    .c1(c1), .c2(c2), .c3(c3),
    .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
    .raster_busy(busy0), .pix_valid(valid0), .pix_ready(pix_ready),
    .pix_x(x0), .pix_y(y0), .raster_done(done0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Scoreboard monitor for the BOTH_WINDINGS=1 instance.
  always @(negedge clk) begin
    if (rst_n) begin
      if (pix_valid && pix_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pix", {pix_x, pix_y}, -1);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          chk("pix_xy", {pix_x, pix_y}, {e.x, e.y});
          chk("pix_cycle", cyc - start_cyc, int'(e.rel));
        end
      end
      if (raster_done) begin
        if (done_q.size() == 0) chk("unexpected_done", cyc - start_cyc, -1);
        else chk("done_cycle", cyc - start_cyc, done_q.pop_front());
        done_cnt++;
      end
    end
  end

  // Observer for the BOTH_WINDINGS=0 instance.
  always @(negedge clk) begin
    if (rst_n && neg_test) begin
      if (valid0) neg_pix++;
      if (done0) done0_rel = cyc - start_cyc;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tri(input int sgn);
    a1 = 10'(0 * sgn);  b1 = 10'(4 * sgn);  c1 = 18'(0 * sgn);
    a2 = 10'(-4 * sgn); b2 = 10'(-4 * sgn); c2 = 18'(16 * sgn);
    a3 = 10'(4 * sgn);  b3 = 10'(0 * sgn);  c3 = 18'(0 * sgn);
    bbxi = 9'd0; bbxf = 9'd4; bbyi = 8'd0; bbyf = 8'd4;
  endtask

  task automatic set_flat(input int xi, input int xf, input int yi, input int yf);
    a1 = 10'sd0; b1 = 10'sd0; c1 = 18'sd1;
    a2 = 10'sd0; b2 = 10'sd0; c2 = 18'sd1;
    a3 = 10'sd0; b3 = 10'sd0; c3 = 18'sd1;
    bbxi = 9'(xi); bbxf = 9'(xf); bbyi = 8'(yi); bbyf = 8'(yf);
  endtask

  // Pixels of triangle (0,0),(4,0),(0,4): x+y<=4 in a 5x5 box.
  task automatic push_tri(input int stall);
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        if (x + y <= 4) exp_q.push_back('{x: 9'(x), y: 8'(y), rel: 16'(2 + y * 5 + x + stall)});
  endtask

  task automatic pulse_start();
    raster_start = 1'b1;
    start_cyc = cyc;
    next_cycle();
    raster_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n0;
    int k;
    n0 = done_cnt;
    k = 0;
    while (done_cnt == n0 && k < budget) begin
      next_cycle();
      k++;
    end
    if (done_cnt == n0) chk("done_timeout", k, -1);
    chk("pix_remaining", exp_q.size(), 0);
  endtask

  initial begin
    set_tri(1);
    repeat (3) next_cycle();
    chk("rst_valid", pix_valid, 0);
    chk("rst_xy", {pix_x, pix_y}, 0);
    chk("rst_busy", raster_busy, 0);
    chk("rst_done", raster_done, 0);
    rst_n = 1'b1;
    next_cycle();

    // Basic triangle, ready held high.
    set_tri(1);
    push_tri(0);
    done_q.push_back(27);
    pulse_start();
    chk("busy_setup", raster_busy, 1);
    wait_done(60);
    chk("busy_idle", raster_busy, 0);

    // Opposite winding.
    set_tri(-1);
    push_tri(0);
    done_q.push_back(27);
    neg_test = 1'b1;
    neg_pix = 0;
    done0_rel = -1;
    pulse_start();
    wait_done(60);
    next_cycle();
    neg_test = 1'b0;
    chk("bw0_no_pix", neg_pix, 0);
    chk("bw0_done", done0_rel, 27);

    // Stall on the first pixel for three cycles.
    set_tri(1);
    push_tri(3);
    done_q.push_back(30);
    pulse_start();
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("stall_valid", pix_valid, 1);
      chk("stall_xy", {pix_x, pix_y}, 0);
    end
    next_cycle();
    pix_ready = 1'b1;
    wait_done(60);

    // Box clipped at the screen edge.
    set_flat(316, 330, 238, 245);
    for (int y = 238; y < 240; y++)
      for (int x = 316; x < 320; x++)
        exp_q.push_back('{x: 9'(x), y: 8'(y), rel: 16'(2 + (y - 238) * 4 + (x - 316))});
    done_q.push_back(10);
    pulse_start();
    wait_done(40);

    // Box entirely off screen.
    set_flat(320, 330, 0, 3);
    done_q.push_back(2);
    pulse_start();
    wait_done(20);

    // Start during a walk is ignored; a start in the next IDLE cycle runs.
    set_tri(1);
    push_tri(0);
    done_q.push_back(27);
    pulse_start();
    repeat (4) next_cycle();
    set_flat(0, 2, 0, 2);
    raster_start = 1'b1;
    next_cycle();
    raster_start = 1'b0;
    wait_done(60);
    set_flat(1, 2, 1, 1);
    exp_q.push_back('{x: 9'd1, y: 8'd1, rel: 16'd2});
    exp_q.push_back('{x: 9'd2, y: 8'd1, rel: 16'd3});
    done_q.push_back(4);
    pulse_start();
    wait_done(20);

    // Reset mid-walk aborts without a done pulse.
    set_tri(1);
    push_tri(0);
    pulse_start();
    repeat (7) next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    exp_q.delete();
    chk("abort_valid", pix_valid, 0);
    chk("abort_xy", {pix_x, pix_y}, 0);
    chk("abort_busy", raster_busy, 0);
    chk("abort_done", raster_done, 0);
    repeat (30) next_cycle();
    chk("abort_no_done", done_cnt, done_cnt);
    set_tri(1);
    push_tri(0);
    done_q.push_back(27);
    pulse_start();
    wait_done(60);

    repeat (3) next_cycle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
